// File: rtl/vertical_reg_ctrl.sv
// vertical_reg_ctrl: sequencer for the vertical register stage feeding the
// select_array. Fills the vertical register with kernel_size columns from one
// bank of the ping-pong line buffer, then slides one column per window, and
// presents every completed window downstream over a valid/ready handshake.
//
// Optional feature macro: VREG_CTRL_TIMEOUT_EN
//   defined   -> watchdog in WAIT; pulses timeout_err_o after WAIT_LIMIT cycles
//                without vr_shift_done_i and aborts the band (no done_o)
//   undefined -> WAIT waits indefinitely, timeout_err_o is constant 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no band active, strobes low, start_i checked here only
// FILL    | reading columns 0..k-1 for the first window (shift_mod 0)
// WAIT    | waiting for vertical_reg to report completion
// PRESENT | window valid downstream, waiting for win_ready_i
// SLIDE   | reading the next single column (shift_mod 1)
// DONE    | one-cycle band completion pulse

`ifndef KERNEL_SIZE
`define KERNEL_SIZE 8
`endif

module vertical_reg_ctrl #(
    parameter int KERNEL_SIZE = `KERNEL_SIZE,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_LIMIT  = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  bank_sel_i,
    input  logic [7:0]            kernel_size_i,
    input  logic [7:0]            out_cols_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o,
    output logic                  buf_rd_en_o,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr_o,
    output logic                  vr_enable_o,
    output logic                  vr_in_select_o,
    output logic                  vr_shift_mod_o,
    input  logic                  vr_shift_done_i,
    output logic                  win_valid_o,
    input  logic                  win_ready_i,
    output logic [7:0]            win_idx_o,
    output logic                  timeout_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT,
        S_PRESENT,
        S_SLIDE,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [7:0]              k_q;
    logic [7:0]              out_cols_q;
    logic [7:0]              c_q;
    logic [7:0]              fill_left_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    cfg_err_q;
    logic                    rd_en_q;
    logic                    rd_slide_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    vr_enable_q;
    logic                    vr_shift_mod_q;
    logic                    in_sel_q;
    logic                    win_valid_q;

    logic                    cfg_ok_d;
    logic                    last_win_d;
    logic [ADDR_WIDTH-1:0]   slide_addr_d;

`ifdef VREG_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(WAIT_LIMIT + 1);
    logic [WD_W-1:0]         wd_q;
    logic                    timeout_q;
`endif

    // Configuration legality and per-window derived values.
    assign cfg_ok_d     = (kernel_size_i != 8'd0) &&
                          (int'(kernel_size_i) <= KERNEL_SIZE) &&
                          (out_cols_i != 8'd0);
    assign last_win_d   = (c_q == out_cols_q - 8'd1);
    // Next column after window c is k+c; wrap-around in the address is intended.
    assign slide_addr_d = ADDR_WIDTH'(k_q) + ADDR_WIDTH'(c_q);

    // Band sequencer with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            out_cols_q     <= '0;
            c_q            <= '0;
            fill_left_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            rd_en_q        <= 1'b0;
            rd_slide_q     <= 1'b0;
            rd_addr_q      <= '0;
            vr_enable_q    <= 1'b0;
            vr_shift_mod_q <= 1'b0;
            in_sel_q       <= 1'b0;
            win_valid_q    <= 1'b0;
`ifdef VREG_CTRL_TIMEOUT_EN
            wd_q           <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            // The buffer returns data one cycle after the read strobe.
            vr_enable_q    <= rd_en_q;
            vr_shift_mod_q <= rd_en_q & rd_slide_q;
`ifdef VREG_CTRL_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (cfg_ok_d) begin
                            k_q         <= kernel_size_i;
                            out_cols_q  <= out_cols_i;
                            in_sel_q    <= bank_sel_i;
                            c_q         <= '0;
                            fill_left_q <= kernel_size_i - 8'd1;
                            rd_en_q     <= 1'b1;
                            rd_slide_q  <= 1'b0;
                            rd_addr_q   <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_FILL;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (fill_left_q == 8'd0) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_WAIT;
`ifdef VREG_CTRL_TIMEOUT_EN
                        wd_q    <= WD_W'(WAIT_LIMIT - 1);
`endif
                    end else begin
                        rd_addr_q   <= rd_addr_q + ADDR_WIDTH'(1);
                        fill_left_q <= fill_left_q - 8'd1;
                    end
                end
                S_WAIT: begin
                    if (vr_shift_done_i) begin
                        win_valid_q <= 1'b1;
                        state_q     <= S_PRESENT;
                    end
`ifdef VREG_CTRL_TIMEOUT_EN
                    else if (wd_q == '0) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wd_q <= wd_q - WD_W'(1);
                    end
`endif
                end
                S_PRESENT: begin
                    if (win_ready_i) begin
                        win_valid_q <= 1'b0;
                        if (last_win_d) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rd_en_q    <= 1'b1;
                            rd_slide_q <= 1'b1;
                            rd_addr_q  <= slide_addr_d;
                            c_q        <= c_q + 8'd1;
                            state_q    <= S_SLIDE;
                        end
                    end
                end
                S_SLIDE: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_WAIT;
`ifdef VREG_CTRL_TIMEOUT_EN
                    wd_q    <= WD_W'(WAIT_LIMIT - 1);
`endif
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign cfg_err_o      = cfg_err_q;
    assign buf_rd_en_o    = rd_en_q;
    assign buf_rd_addr_o  = rd_addr_q;
    assign vr_enable_o    = vr_enable_q;
    assign vr_in_select_o = in_sel_q;
    assign vr_shift_mod_o = vr_shift_mod_q;
    assign win_valid_o    = win_valid_q;
    assign win_idx_o      = c_q;
`ifdef VREG_CTRL_TIMEOUT_EN
    assign timeout_err_o  = timeout_q;
`else
    assign timeout_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_vertical_reg_ctrl.sv
// Self-checking bench for vertical_reg_ctrl. A negedge monitor collects the
// column-read stream, shift modes and accepted window indices; each band is
// compared against the column sequence a k-wide sliding window must produce.

module tb_vertical_reg_ctrl;

    localparam int KS = 8;
    localparam int AW = 8;
    localparam int WL = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bank_sel;
    logic [7:0]    kernel_size;
    logic [7:0]    out_cols;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic          vr_enable;
    logic          vr_in_select;
    logic          vr_shift_mod;
    logic          vr_shift_done;
    logic          win_valid;
    logic          win_ready;
    logic [7:0]    win_idx;
    logic          timeout_err;

    always #5 clk = ~clk;

    vertical_reg_ctrl #(
        .KERNEL_SIZE(KS),
        .ADDR_WIDTH (AW),
        .WAIT_LIMIT (WL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .bank_sel_i     (bank_sel),
        .kernel_size_i  (kernel_size),
        .out_cols_i     (out_cols),
        .busy_o         (busy),
        .done_o         (done),
        .cfg_err_o      (cfg_err),
        .buf_rd_en_o    (buf_rd_en),
        .buf_rd_addr_o  (buf_rd_addr),
        .vr_enable_o    (vr_enable),
        .vr_in_select_o (vr_in_select),
        .vr_shift_mod_o (vr_shift_mod),
        .vr_shift_done_i(vr_shift_done),
        .win_valid_o    (win_valid),
        .win_ready_i    (win_ready),
        .win_idx_o      (win_idx),
        .timeout_err_o  (timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor / responder state
    int   q_addr[$];
    int   q_mod[$];
    int   q_idx[$];
    int   done_cnt = 0;
    int   cfg_cnt  = 0;
    int   to_cnt   = 0;
    int   since    = 1000;
    bit   resp_en  = 1'b0;
    int   resp_delay = 3;
    bit   ready_always = 1'b1;
    int   stall_left = 0;
    int   exp_n = 1;
    bit   exp_bank = 1'b0;
    logic prev_rd_en = 1'b0;
    logic prev_rst = 1'b1;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_done = 1'b0;
    logic prev_hs = 1'b0;
    logic prev_hs_last = 1'b0;
    logic [7:0] prev_idx = '0;

    // Sample outputs, check cycle-level rules, then drive ready/shift_done.
    always @(negedge clk) begin
        logic hs;
        if (!rst) begin
            if (buf_rd_en) q_addr.push_back(int'(buf_rd_addr));
            if (vr_enable) begin
                q_mod.push_back(int'(vr_shift_mod));
                chk("in_select", vr_in_select, exp_bank);
            end
            if (done)        done_cnt++;
            if (cfg_err)     cfg_cnt++;
            if (timeout_err) to_cnt++;
            if (!prev_rst) chk("vr_en_delay", vr_enable, prev_rd_en);
            if (win_valid) chk("no_read_while_valid", buf_rd_en, 0);
            if (prev_valid && !prev_ready && !prev_rst) begin
                chk("valid_held", win_valid, 1);
                chk("idx_stable", win_idx, prev_idx);
            end
            if (prev_done) begin
                chk("done_one_cycle", done, 0);
                chk("busy_after_done", busy, 0);
            end
            if (prev_hs_last) chk("done_after_last_hs", done, 1);
            if (prev_hs && !prev_hs_last) begin
                chk("slide_read_after_hs", buf_rd_en, 1);
                chk("valid_drop_after_hs", win_valid, 0);
            end
        end
        since = vr_enable ? 0 : ((since < 1000) ? since + 1 : since);
        vr_shift_done = resp_en && (since == resp_delay);
        if (win_valid && stall_left > 0) begin
            win_ready = 1'b0;
            stall_left--;
        end else begin
            win_ready = ready_always ? 1'b1 : 1'($urandom_range(0, 1));
        end
        hs = !rst && win_valid && win_ready;
        if (hs) q_idx.push_back(int'(win_idx));
        prev_hs      = hs;
        prev_hs_last = hs && (int'(win_idx) == exp_n - 1);
        prev_rd_en   = buf_rd_en;
        prev_rst     = rst;
        prev_valid   = win_valid;
        prev_ready   = win_ready;
        prev_done    = done;
        prev_idx     = win_idx;
    end

    function automatic logic [31:0] all_outputs();
        return {7'd0, busy, done, cfg_err, buf_rd_en, buf_rd_addr, vr_enable,
                vr_in_select, vr_shift_mod, win_valid, win_idx, timeout_err};
    endfunction

    // One band: a sliding window reads columns 0,1,2,... in order; the first
    // k reads fill (mode 0), each later read slides (mode 1); windows 0..n-1.
    task automatic run_band(input int k, input int n, input bit bank, input int dly,
                            input bit rdy_all, input int stall, input bit extra_start);
        int nr;
        q_addr.delete(); q_mod.delete(); q_idx.delete();
        done_cnt = 0; cfg_cnt = 0; to_cnt = 0;
        exp_bank = bank; exp_n = n; resp_delay = dly; resp_en = 1'b1;
        ready_always = rdy_all; stall_left = stall;
        @(negedge clk);
        start = 1'b1; kernel_size = 8'(k); out_cols = 8'(n); bank_sel = bank;
        @(posedge clk); #1;
        chk("busy_t1", busy, 1);
        chk("rd_en_t1", buf_rd_en, 1);
        chk("addr_t1", buf_rd_addr, 0);
        chk("vr_en_t1", vr_enable, 0);
        if (extra_start) begin
            kernel_size = 8'd0;
            repeat (3) @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int c = 0; c < 40 * n + 200 && done_cnt == 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("band_done_count", done_cnt, 1);
        chk("busy_end", busy, 0);
        chk("cfg_err_in_band", cfg_cnt, 0);
        chk("timeout_in_band", to_cnt, 0);
        nr = k + n - 1;
        chk("num_reads", q_addr.size(), nr);
        chk("num_enables", q_mod.size(), nr);
        chk("num_windows", q_idx.size(), n);
        for (int i = 0; i < nr && i < q_addr.size(); i++)
            chk("rd_addr", q_addr[i], i % (1 << AW));
        for (int i = 0; i < nr && i < q_mod.size(); i++)
            chk("shift_mod", q_mod[i], (i < k) ? 0 : 1);
        for (int i = 0; i < n && i < q_idx.size(); i++)
            chk("win_idx", q_idx[i], i);
    endtask

    task automatic bad_start(input int k, input int n);
        @(negedge clk);
        start = 1'b1; kernel_size = 8'(k); out_cols = 8'(n); bank_sel = 1'b1;
        @(posedge clk); #1;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_err_no_read", buf_rd_en, 0);
    endtask

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; bank_sel = 1'b0; kernel_size = '0; out_cols = '0;
        vr_shift_done = 1'b0; win_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outputs(), 0);
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_band(5, 1, 1'b1, 3, 1'b1, 0, 1'b0);
        run_band(3, 4, 1'b0, 2, 1'b1, 0, 1'b0);
        run_band(4, 2, 1'b1, 1, 1'b1, 10, 1'b0);

        bad_start(0, 3);
        bad_start(KS + 1, 3);
        bad_start(3, 0);
        run_band(2, 2, 1'b0, 1, 1'b1, 0, 1'b1);

        // Reset during the third fill read aborts the band.
        done_cnt = 0; exp_bank = 1'b1; exp_n = 2; resp_en = 1'b1; resp_delay = 2;
        @(negedge clk);
        start = 1'b1; kernel_size = 8'd5; out_cols = 8'd2; bank_sel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (buf_rd_en && buf_rd_addr == AW'(2)) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("rst_third_read_seen", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_outputs", all_outputs(), 0);
        #3 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt, 0);
        chk("busy_after_rst", busy, 0);
        run_band(3, 2, 1'b0, 1, 1'b1, 0, 1'b0);

        for (int b = 0; b < 8; b++)
            run_band($urandom_range(1, KS), $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        // Long band: column address wraps past 2^AW.
        run_band(KS, 252, 1'b1, 0, 1'b1, 0, 1'b0);

`ifdef VREG_CTRL_TIMEOUT_EN
        begin
            int last_rd;
            int to_at;
            resp_en = 1'b0; to_cnt = 0; done_cnt = 0; exp_bank = 1'b0; exp_n = 2;
            @(negedge clk);
            start = 1'b1; kernel_size = 8'd3; out_cols = 8'd2; bank_sel = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            last_rd = -100; to_at = -1;
            for (int c = 1; c <= 60; c++) begin
                if (buf_rd_en) last_rd = c;
                if (timeout_err && to_at < 0) begin
                    to_at = c;
                    chk("busy_at_timeout", busy, 0);
                end
                @(posedge clk); #1;
            end
            chk("timeout_latency", to_at - last_rd, WL + 1);
            chk("timeout_pulses", to_cnt, 1);
            chk("timeout_no_done", done_cnt, 0);
            resp_en = 1'b1;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
